uart_cmd_decoder: RTL
=====================

Name: uart_cmd_decoder

Overview:
- Sits directly downstream of the UART receiver inside uart_top.
- Consumes the received byte stream (rx_data, rx_done) and turns ASCII command characters into one-cycle control pulses, which are OR-ed with the debounced board buttons downstream.
- Drives the mode register that selects stopwatch or watch display.
- Queues an echo/acknowledge byte per received character and hands it to the UART transmitter through a start/busy handshake.

Parameters:
- FIFO_DEPTH, 4, entries in the echo FIFO; power of two, minimum 2.
- ECHO_EN, 1, 1 = echo every received byte on tx; 0 = FIFO and tx path held idle.
- ERR_CHAR, 8'h3F, byte echoed in place of any unrecognised character ('?').

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  byte from UART receiver; valid while rx_done is high
- rx_done  in  1  one-cycle strobe, byte received
- tx_busy  in  1  UART transmitter busy, high from the cycle after tx_start until the stop bit ends
- tx_start  out  1  one-cycle request to the transmitter
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_busy falls
- o_btn_ctl  out  4  command pulses: [0]=Clear(L), [1]=Run/Stop(R), [2]=Minute+(U), [3]=Hour+(D)
- o_watch_rst  out  1  one-cycle pulse, watch reset to 12:00
- o_mode  out  2  00 = stopwatch sec/msec, 01 = stopwatch hour/min, 10 = watch
- o_cmd_err  out  1  one-cycle pulse on an unrecognised byte
- o_ovf  out  1  one-cycle pulse when an echo byte is dropped because the FIFO is full

Behaviour:
Reset:
- All outputs are 0 and o_mode = 00.
- FIFO is empty and the tx FSM is in IDLE.
- Reset asserted mid-transfer aborts the FSM immediately. No tx_start is issued after release until a new byte arrives.

Decode (registered, latency 1):
- rx_done high in cycle N produces the outputs in cycle N+1, each exactly 1 cycle wide.
- Upper and lower case are equivalent.
- 'C' -> o_btn_ctl[0]; 'S' -> [1]; 'M' -> [2]; 'H' -> [3]; 'R' -> o_watch_rst.
- '0' / '1' / '2' -> o_mode = 00 / 01 / 10. The new value is visible at N+1 and held until the next mode command or reset.
- Any other byte -> o_cmd_err; no other output changes.
- Command pulses are not gated by o_mode. Mode qualification belongs to the consumers.

Echo FIFO:
- On rx_done with ECHO_EN = 1, push rx_data, or ERR_CHAR for an unrecognised byte.
- The pointer width is log2(FIFO_DEPTH) + 1 bits. Full when the pointers differ only in the MSB; empty when they are equal. Pointers wrap modulo 2*FIFO_DEPTH.
- Push while full: byte dropped, o_ovf pulses at N+1, contents unchanged.
- Push and pop in the same cycle: both take effect. A push is accepted when full only if the pop happens in that same cycle.
- ECHO_EN = 0: no pushes and tx_start is never asserted.

Tx FSM (states IDLE, START, WAIT_BUSY, WAIT_DONE):
- IDLE: if the FIFO is non-empty, latch the head into tx_data, pop, and go to START.
- START: tx_start = 1 for exactly one cycle, then WAIT_BUSY.
- WAIT_BUSY: wait for tx_busy = 1, then WAIT_DONE. If tx_busy is already high, the transition takes 1 cycle.
- WAIT_DONE: wait for tx_busy = 0, then IDLE.
- Back-to-back echoes: the next tx_start comes no earlier than 2 cycles after tx_busy falls.
- tx_data changes only in IDLE.

Simultaneous events:
- rx_done arriving in any FSM state is decoded and pushed normally. Decode never stalls on tx.

Test Plan:
1. Reset, then send '2' then 'R' -> o_mode = 10 one cycle after the first rx_done; a single 1-cycle o_watch_rst after the second; tx carries 0x32 then 0x52.
2. With mode 10, send 'M', 'h', 'S', 'c' -> o_btn_ctl equals 0100, 1000, 0010, 0001 in turn, each exactly 1 cycle, at rx_done+1; the echo sequence is 4D 68 53 63.
3. Send 'x' (0x78) -> o_cmd_err pulses once, o_mode and o_btn_ctl unchanged, 0x3F echoed.
4. Hold tx_busy high and inject 6 rx_done strobes (FIFO_DEPTH = 4) -> first byte latched; 4 bytes queued, the 6th dropped with o_ovf = 1 one cycle later; on tx_busy release exactly 5 bytes go out in order.
5. Assert rst during WAIT_DONE with 2 bytes queued -> all outputs 0, o_mode = 00, FIFO empty, no tx_start after release until a new rx_done.
6. Pulse rx_done in the same cycle the FSM pops from a full FIFO -> push accepted, no o_ovf, order preserved.

Source files
------------

// File: rtl/uart_cmd_decoder_if.sv
// uart_cmd_decoder_if: rx byte stream in, tx handshake and command outputs between decoder and UART
interface uart_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] o_btn_ctl;
  logic       o_watch_rst;
  logic [1:0] o_mode;
  logic       o_cmd_err;
  logic       o_ovf;
  modport master (
    output rx_data, rx_done, tx_busy,
    input  tx_start, tx_data, o_btn_ctl, o_watch_rst, o_mode, o_cmd_err, o_ovf
  );
  modport slave (
    input  rx_data, rx_done, tx_busy,
    output tx_start, tx_data, o_btn_ctl, o_watch_rst, o_mode, o_cmd_err, o_ovf
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: ASCII command decode to control pulses, mode register and echo FIFO feeding the UART tx
module uart_cmd_decoder #(
  parameter int         FIFO_DEPTH = 4,
  parameter bit         ECHO_EN    = 1'b1,
  parameter logic [7:0] ERR_CHAR   = 8'h3F
) (
  input logic clk,
  input logic rst,
  uart_cmd_decoder_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT_BUSY = 2'd2, WAIT_DONE = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [3:0]  btn_ctl_q, btn_ctl_d;
  logic        watch_rst_q, watch_rst_d, cmd_err_q, cmd_err_d, ovf_q, ovf_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [7:0]  up, echo;
  logic [3:0]  btn;
  logic        wr_cmd, mode_cmd, known, full, empty, push_req, push, pop;
  always_comb begin
    up          = (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h7A) ? bus.rx_data - 8'h20 : bus.rx_data;
    btn         = {up == 8'h48, up == 8'h4D, up == 8'h53, up == 8'h43};
    wr_cmd      = up == 8'h52;
    mode_cmd    = up inside {8'h30, 8'h31, 8'h32};
    known       = |btn | wr_cmd | mode_cmd;
    echo        = known ? bus.rx_data : ERR_CHAR;
    btn_ctl_d   = bus.rx_done ? btn : 4'h0;
    watch_rst_d = bus.rx_done & wr_cmd;
    cmd_err_d   = bus.rx_done & ~known;
    mode_d      = (bus.rx_done & mode_cmd) ? up[1:0] : mode_q;
    empty       = wr_ptr_q == rd_ptr_q;
    full        = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    pop         = state_q == IDLE && !empty;
    // a full FIFO still accepts when the head leaves in the same cycle
    push_req    = ECHO_EN && bus.rx_done;
    push        = push_req && (!full || pop);
    ovf_d       = push_req && !push;
    wr_ptr_d    = wr_ptr_q + (AW + 1)'(push);
    rd_ptr_d    = rd_ptr_q + (AW + 1)'(pop);
    tx_data_d   = pop ? mem[rd_ptr_q[AW-1:0]] : tx_data_q;
    state_d     = state_q == IDLE      ? (empty ? IDLE : START) :
                  state_q == START     ? WAIT_BUSY :
                  state_q == WAIT_BUSY ? (bus.tx_busy ? WAIT_DONE : WAIT_BUSY) :
                                         (bus.tx_busy ? WAIT_DONE : IDLE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      btn_ctl_q   <= '0;
      watch_rst_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
      mode_q      <= 2'b00;
      tx_data_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      btn_ctl_q   <= btn_ctl_d;
      watch_rst_q <= watch_rst_d;
      cmd_err_q   <= cmd_err_d;
      ovf_q       <= ovf_d;
      mode_q      <= mode_d;
      tx_data_q   <= tx_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= echo;
  end
  assign bus.tx_start    = state_q == START;
  assign bus.tx_data     = tx_data_q;
  assign bus.o_btn_ctl   = btn_ctl_q;
  assign bus.o_watch_rst = watch_rst_q;
  assign bus.o_mode      = mode_q;
  assign bus.o_cmd_err   = cmd_err_q;
  assign bus.o_ovf       = ovf_q;
endmodule
